// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, bit timing default
// and the transmit scheduler state encoding.
package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int CLK_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO,
    GAP
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first masked request after the
// previous winner, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  logic hit;

  // scan last+1, last+2, ... and take the first eligible request
  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int j = 1; j <= N_REQ; j++) begin
      for (int p = 0; p < N_REQ; p++) begin
        if (!hit && req[p] && mask[p] &&
            p == (int'(last) + j) % N_REQ) begin
          hit      = 1'b1;
          grant[p] = 1'b1;
          idx      = IDW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between N_REQ byte streams with
// round-robin arbitration, packet locking and a frame gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int IDW          = 2,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 8,
  parameter int LOCK_PACKETS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    locked,
  output logic                    err_timeout
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD =
    CNT_W'(GAP_CYCLES - 1);

  sched_state_e state, nstate;

  logic [IDW-1:0]    last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_REQ-1:0]  mask;
  logic [N_REQ-1:0]  grant;
  logic [IDW-1:0]    win_idx;
  logic [BYTE_W-1:0] win_byte;
  logic              win_last;
  logic              found;

  // while locked only the owning requester is eligible
  always_comb begin
    mask = '0;
    for (int p = 0; p < N_REQ; p++)
      mask[p] = !locked || grant_id == IDW'(p);
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .mask  (mask),
    .grant (grant),
    .idx   (win_idx)
  );

  assign found = |grant;

  // select the winning requester's byte and last flag
  always_comb begin
    win_byte = '0;
    win_last = 1'b0;
    for (int p = 0; p < N_REQ; p++) begin
      if (grant[p]) begin
        win_byte = req_data[p*BYTE_W +: BYTE_W];
        win_last = req_last[p];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (found) nstate = LAUNCH;
      LAUNCH:  nstate = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy)             nstate = WAIT_LO;
        else if (cnt_q == TO_LAST) nstate = IDLE;
      end
      WAIT_LO: begin
        if (!tx_busy)
          nstate = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP:     if (cnt_q == '0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // handshake and launch strobes; ready is held off in reset
  always_comb begin
    tx_start  = state == LAUNCH;
    req_ready = (state == IDLE && rst) ? grant : '0;
  end

  // byte capture, ownership, lock, counters and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data     <= '0;
      grant_id    <= '0;
      last_q      <= IDW'(N_REQ - 1);
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      cnt_q       <= '0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= win_byte;
            grant_id <= win_idx;
            last_q   <= win_idx;
            locked   <= (LOCK_PACKETS != 0) & ~win_last;
          end
        end
        LAUNCH: cnt_q <= '0;
        WAIT_HI: begin
          if (!tx_busy) begin
            if (cnt_q == TO_LAST) begin
              err_timeout <= 1'b1;
              locked      <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        WAIT_LO: if (!tx_busy) cnt_q <= GAP_LOAD;
        GAP:     if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler: two instances
// (gap 0 and gap 3) checked against a transaction model.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int BT  = 8;
  localparam int NI  = 2;
  localparam int INF = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic [N-1:0]   rv  [NI];
  logic [N-1:0]   rl  [NI];
  logic [N-1:0]   rr  [NI];
  logic [8*N-1:0] rd  [NI];
  logic           ts  [NI];
  logic           tb  [NI];
  logic           lk  [NI];
  logic           et  [NI];
  logic [7:0]     td  [NI];
  logic [1:0]     gid [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    uart_tx_scheduler #(
      .N_REQ        (N),
      .IDW          (2),
      .GAP_CYCLES   (3 * k),
      .BUSY_TIMEOUT (BT),
      .LOCK_PACKETS (1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (rv[k]),
      .req_data    (rd[k]),
      .req_last    (rl[k]),
      .req_ready   (rr[k]),
      .tx_start    (ts[k]),
      .tx_data     (td[k]),
      .tx_busy     (tb[k]),
      .grant_id    (gid[k]),
      .locked      (lk[k]),
      .err_timeout (et[k])
    );
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [8:0] mem [NI][N][64];
  int hd [NI][N];
  int tl [NI][N];

  int lp [NI];
  int lockown [NI];
  int lastid [NI];
  int ready_at [NI];
  int exp_start [NI];
  int err_at [NI];
  int pend [NI];
  logic [7:0] exp_dat [NI];
  logic waitfall [NI];
  logic prevb [NI];
  int bs [NI];
  int be [NI];
  int force_dead;
  int rand_dead;
  int fixed_len;

  logic [7:0] dlog [NI][16];
  int st_log [NI][16];
  int fl_log [NI][16];
  int dn [NI];
  int fn [NI];
  int errc [NI];

  function automatic int gap(input int k);
    return 3 * k;
  endfunction

  function automatic string tg(input int k, input string s);
    return $sformatf("u%0d.%s", k, s);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(input int k, input int i,
                      input logic [7:0] b,
                      input logic last);
    mem[k][i][tl[k][i] % 64] = {last, b};
    tl[k][i]++;
  endtask

  task automatic flush(input int k);
    for (int i = 0; i < N; i++) hd[k][i] = tl[k][i];
    pend[k]      = -1;
    exp_start[k] = -1;
    err_at[k]    = -1;
    waitfall[k]  = 1'b0;
  endtask

  task automatic model_reset(input int k);
    lp[k]       = N - 1;
    lockown[k]  = -1;
    lastid[k]   = 0;
    ready_at[k] = cyc;
    exp_start[k] = -1;
    err_at[k]   = -1;
    pend[k]     = -1;
    waitfall[k] = 1'b0;
  endtask

  task automatic clr_logs();
    for (int k = 0; k < NI; k++) begin
      dn[k]   = 0;
      fn[k]   = 0;
      errc[k] = -1;
    end
  endtask

  task automatic drive(input int k);
    logic nb;
    logic [8:0] e;
    if (pend[k] >= 0) begin
      hd[k][pend[k]]++;
      pend[k] = -1;
    end
    nb = cyc >= bs[k] && cyc <= be[k];
    if (prevb[k] && !nb) begin
      if (fn[k] < 16) fl_log[k][fn[k]] = cyc;
      fn[k]++;
      if (waitfall[k]) begin
        ready_at[k] = cyc + gap(k) + 1;
        waitfall[k] = 1'b0;
      end
    end
    prevb[k] = nb;
    tb[k]    = nb;
    for (int i = 0; i < N; i++) begin
      if (hd[k][i] < tl[k][i]) begin
        e = mem[k][i][hd[k][i] % 64];
        rv[k][i] = 1'b1;
        rl[k][i] = e[8];
        rd[k][i*8 +: 8] = e[7:0];
      end else begin
        rv[k][i] = 1'b0;
        rl[k][i] = 1'b0;
        rd[k][i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic rst_chk(input int k);
    chk(tg(k, "rst.ready"), 32'(rr[k]), 0);
    chk(tg(k, "rst.start"), 32'(ts[k]), 0);
    chk(tg(k, "rst.data"), 32'(td[k]), 0);
    chk(tg(k, "rst.grant"), 32'(gid[k]), 0);
    chk(tg(k, "rst.locked"), 32'(lk[k]), 0);
    chk(tg(k, "rst.err"), 32'(et[k]), 0);
  endtask

  task automatic step(input int k);
    int c;
    int w;
    int p;
    int len;
    logic [8:0] e;
    logic dead;
    c = cyc;
    if (c == err_at[k]) begin
      lockown[k]  = -1;
      ready_at[k] = c;
    end
    chk(tg(k, "locked"), 32'(lk[k]),
        32'(lockown[k] >= 0));
    chk(tg(k, "err"), 32'(et[k]), 32'(c == err_at[k]));
    chk(tg(k, "start"), 32'(ts[k]),
        32'(c == exp_start[k]));
    chk(tg(k, "grant_id"), 32'(gid[k]), lastid[k]);
    if (et[k]) errc[k] = c;
    if (ts[k]) begin
      if (dn[k] < 16) begin
        dlog[k][dn[k]]   = td[k];
        st_log[k][dn[k]] = c;
      end
      dn[k]++;
    end
    if (c == exp_start[k]) begin
      chk(tg(k, "tx_data"), 32'(td[k]), 32'(exp_dat[k]));
      dead = force_dead != 0 ||
             (rand_dead != 0 && $urandom_range(0, 7) == 0);
      if (dead) begin
        err_at[k]   = c + BT + 1;
        waitfall[k] = 1'b0;
      end else if (!tb[k]) begin
        len = fixed_len > 0 ? fixed_len
                            : int'($urandom_range(1, 6));
        bs[k] = c + 1;
        be[k] = c + len;
      end
    end
    w = -1;
    if (c >= ready_at[k]) begin
      if (lockown[k] >= 0) begin
        if (hd[k][lockown[k]] < tl[k][lockown[k]])
          w = lockown[k];
      end else begin
        for (int j = 1; j <= N; j++) begin
          p = (lp[k] + j) % N;
          if (w < 0 && hd[k][p] < tl[k][p]) w = p;
        end
      end
    end
    chk(tg(k, "ready"), 32'(rr[k]),
        w >= 0 ? (1 << w) : 0);
    if (w >= 0) begin
      e = mem[k][w][hd[k][w] % 64];
      exp_dat[k]   = e[7:0];
      lastid[k]    = w;
      lp[k]        = w;
      lockown[k]   = e[8] ? -1 : w;
      ready_at[k]  = INF;
      waitfall[k]  = 1'b1;
      exp_start[k] = c + 1;
      pend[k]      = w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NI; k++) drive(k);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (rst) step(k);
      else     rst_chk(k);
    end
  endtask

  function automatic logic all_idle();
    logic r;
    r = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (ready_at[k] > cyc || pend[k] >= 0) r = 1'b0;
      for (int i = 0; i < N; i++)
        if (hd[k][i] < tl[k][i]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (!all_idle() && n < maxc) begin
      tick();
      n++;
    end
    chk("drain.timeout", 32'(all_idle()), 1);
  endtask

  task automatic release_rst();
    #3;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) model_reset(k);
  endtask

  task automatic log_chk(input int k, input int idx,
                         input logic [7:0] exp);
    chk(tg(k, $sformatf("order%0d", idx)),
        32'(dlog[k][idx]), 32'(exp));
  endtask

  initial begin
    int n;
    logic [7:0] a4;
    force_dead = 0;
    rand_dead  = 0;
    fixed_len  = 0;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < N; i++) begin
        hd[k][i] = 0;
        tl[k][i] = 0;
      end
      bs[k] = -10;
      be[k] = -10;
      prevb[k] = 1'b0;
      tb[k] = 1'b0;
      rv[k] = '0;
      rl[k] = '0;
      rd[k] = '0;
      model_reset(k);
    end
    clr_logs();

    repeat (3) tick();
    release_rst();

    // lock: req1 must wait while req0's packet is open
    clr_logs();
    for (int k = 0; k < NI; k++) begin
      push(k, 0, 8'h10, 1'b0);
      push(k, 1, 8'h20, 1'b1);
    end
    repeat (30) tick();
    for (int k = 0; k < NI; k++) begin
      push(k, 0, 8'h11, 1'b0);
      push(k, 0, 8'h12, 1'b1);
    end
    drain(400);
    for (int k = 0; k < NI; k++) begin
      chk(tg(k, "lock.count"), dn[k], 4);
      log_chk(k, 0, 8'h10);
      log_chk(k, 1, 8'h11);
      log_chk(k, 2, 8'h12);
      log_chk(k, 3, 8'h20);
    end

    // async reset in the middle of a locked frame
    fixed_len = 20;
    for (int k = 0; k < NI; k++) begin
      push(k, 2, 8'h30, 1'b0);
      push(k, 2, 8'h31, 1'b0);
    end
    n = 0;
    while (n < 60 &&
           !(tb[0] && tb[1] &&
             cyc >= exp_start[0] + 2 &&
             cyc >= exp_start[1] + 2 &&
             lockown[0] == 2 && lockown[1] == 2)) begin
      tick();
      n++;
    end
    chk("rst.reach_wait_lo", 32'(n < 60), 1);
    #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      rst_chk(k);
      flush(k);
    end
    repeat (2) tick();
    release_rst();
    fixed_len = 0;
    n = 0;
    while (n < 40 && (tb[0] || tb[1])) begin
      tick();
      n++;
    end
    chk("rst.busy_drop", 32'(n < 40), 1);

    // all four requesters, plus a second byte on req0
    clr_logs();
    a4 = 8'hA4;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < N; i++)
        push(k, i, 8'hA0 + 8'(i), 1'b1);
      push(k, 0, a4, 1'b1);
    end
    drain(600);
    for (int k = 0; k < NI; k++) begin
      chk(tg(k, "rr.count"), dn[k], 5);
      for (int j = 0; j < 5; j++)
        log_chk(k, j, 8'hA0 + 8'(j));
      for (int j = 0; j < 4; j++)
        chk(tg(k, $sformatf("spacing%0d", j)),
            st_log[k][j+1] - fl_log[k][j], gap(k) + 2);
    end

    // single request
    clr_logs();
    for (int k = 0; k < NI; k++) push(k, 0, 8'h55, 1'b1);
    drain(200);
    for (int k = 0; k < NI; k++) begin
      chk(tg(k, "single.count"), dn[k], 1);
      log_chk(k, 0, 8'h55);
    end

    // busy never rises; lock must be released by timeout
    clr_logs();
    force_dead = 1;
    for (int k = 0; k < NI; k++) push(k, 1, 8'h66, 1'b0);
    drain(200);
    force_dead = 0;
    for (int k = 0; k < NI; k++) push(k, 2, 8'h77, 1'b1);
    drain(200);
    for (int k = 0; k < NI; k++) begin
      chk(tg(k, "to.delay"), errc[k] - st_log[k][0], BT + 1);
      chk(tg(k, "to.count"), dn[k], 2);
      log_chk(k, 1, 8'h77);
    end

    // random packets with occasional dead frames
    rand_dead = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < NI; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          int i;
          int len;
          i   = int'($urandom_range(0, N - 1));
          len = int'($urandom_range(1, 3));
          if (tl[k][i] - hd[k][i] < 48)
            for (int b = 0; b < len; b++)
              push(k, i, 8'($urandom), b == len - 1);
        end
      end
      tick();
    end
    rand_dead = 0;
    drain(4000);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_tx transmitter between N_REQ byte-stream requesters.
- Uses round-robin arbitration with optional packet locking.
- Each byte is issued as a one-cycle start pulse, then the scheduler tracks the transmitter's busy flag and enforces a programmable inter-frame gap.
- Sits between requester logic and the uart_tx instance inside the UART top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, grant index width; must equal clog2(N_REQ).
- GAP_CYCLES, 0, idle clk cycles inserted after busy falls, before the next start.
- BUSY_TIMEOUT, 8, max cycles to wait for tx_busy to rise after tx_start.
- LOCK_PACKETS, 1, 1 = keep grant on a requester until a byte with req_last=1 is sent.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  8*N_REQ  requester i byte on bits [8i+7:8i].
- req_last  in  N_REQ  byte ends that requester's packet.
- req_ready  out  N_REQ  byte accepted this cycle (one-hot or zero).
- tx_start  out  1  one-cycle launch pulse to uart_tx.
- tx_data  out  8  byte to uart_tx, stable from tx_start until busy falls.
- tx_busy  in  1  uart_tx busy.
- grant_id  out  IDW  requester owning the current or last byte.
- locked  out  1  mid-packet lock active.
- err_timeout  out  1  one-cycle pulse: tx_busy never rose.

Behaviour:
- Reset (rst=0, async) values:
  - tx_start=0, tx_data=0, req_ready=0, grant_id=0, locked=0, err_timeout=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 wins first.
  - State=IDLE, gap counter=0.
- Reset asserted mid-transfer aborts the transfer: no further start, lock cleared. The byte already in uart_tx is not recalled.
- States: IDLE, LAUNCH, WAIT_HI, WAIT_LO, GAP.
- IDLE:
  - Candidate set: if locked, only requester grant_id; otherwise all.
  - Winner: first valid index scanning last+1, last+2, … modulo N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; the handshake completes in that cycle.
  - Registered on that edge:
    - tx_data <= winner's byte; grant_id <= winner; last <= winner.
    - locked <= LOCK_PACKETS & ~req_last[winner].
  - Next state LAUNCH. No valid candidate: stay in IDLE, req_ready=0.
- LAUNCH: tx_start=1 for exactly this cycle; go to WAIT_HI, timeout counter=0.
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - Otherwise count up; at count==BUSY_TIMEOUT-1 pulse err_timeout, clear locked, go to IDLE.
- WAIT_LO:
  - Wait for tx_busy=0.
  - Then go to GAP if GAP_CYCLES>0 (load counter), else to IDLE.
  - No timeout in this state.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Total start-to-start spacing ≥ frame + GAP_CYCLES + 2.
- Locked with locked requester's valid low: stay in IDLE, no other requester is served.
- req_ready is never asserted outside IDLE. At most one bit is ever high.
- tx_busy already high on entry to IDLE (external misuse): IDLE still arbitrates. uart_tx is responsible for ignoring the start; the scheduler then sees busy and proceeds normally.
- Requester valid/data/last must hold until ready. The scheduler does not buffer beyond the single tx_data register.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding enum (IDLE, LAUNCH, WAIT_HI, WAIT_LO, GAP);
  - BYTE_W=8;
  - default CLK_PER_BIT shared with uart_tx/uart_rx.
- One natural sub-module: rr_arbiter.
  - Combinational, N_REQ-wide.
  - Inputs: request vector, last pointer, lock mask.
  - Outputs: one-hot grant and index.
- The scheduler FSM, counters and registers stay in uart_tx_scheduler.

Test Plan:
- Single request, GAP=0: req_valid=0001, data 0x55, last=1 → req_ready[0] 1 cycle, tx_start 1 cycle later, tx_data=0x55, grant_id=0, locked=0.
- All four valid, last=1 each, bytes 0xA0..0xA3 → start order 0,1,2,3,0. Each start follows busy falling, ≥ GAP_CYCLES idle between.
- Lock: req0 sends 0x10(last=0), 0x11(last=0), 0x12(last=1) while req1 holds 0x20 → order 0x10,0x11,0x12,0x20; locked high from first handshake until the 0x12 handshake.
- Timeout: tx_busy tied 0 → err_timeout pulses exactly BUSY_TIMEOUT+1 cycles after tx_start; FSM back in IDLE; locked=0.
- Async reset mid-WAIT_LO with req2 locked → all outputs at reset values immediately. After release, requester 0 wins first.
- GAP_CYCLES=3: two back-to-back requests → exactly 3 idle cycles plus IDLE/LAUNCH between busy falling and the next tx_start.
